// File: rtl/sram_word_master_if.sv
// rtl/sram_word_master_if.sv - word request/response bundle between FPGA logic and sram_word_master
interface sram_word_master_if;
    logic        REQ;
    logic        WR;
    logic [17:0] ADDR;
    logic [15:0] WDATA;
    logic [1:0]  BE;
    logic [15:0] RDATA;
    logic        ACK;
    logic        BUSY;

    modport master (
        output REQ, WR, ADDR, WDATA, BE,
        input  RDATA, ACK, BUSY
    );

    modport slave (
        input  REQ, WR, ADDR, WDATA, BE,
        output RDATA, ACK, BUSY
    );
endinterface

// File: rtl/sram_word_master.sv
// rtl/sram_word_master.sv - 16-bit word master issuing up to two byte cycles on an 8-bit async SRAM
module sram_word_master #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                NRESET,
    sram_word_master_if.slave   bus,
    inout  wire  [7:0]          SRAM_D,
    output logic [18:0]         SRAM_A,
    output logic                SRAM_CS,
    output logic                SRAM_OE,
    output logic                SRAM_WE
);

    localparam int WC_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CW     = $clog2(WC_EFF + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           sel_q;
    logic           wr_q;
    logic [17:0]    addr_q;
    logic [15:0]    wdata_q;
    logic [1:0]     be_q;
    logic [15:0]    rbuf_q;
    logic [15:0]    rdata_q;
    logic           ack_q;
    logic           busy_q;
    logic [18:0]    a_q;
    logic           cs_n_q;
    logic           oe_n_q;
    logic           we_n_q;
    logic           drive_q;
    logic [7:0]     dout_q;

    // Low byte goes first whenever it is enabled.
    logic first_sel;
    assign first_sel = ~bus.BE[0];

    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            a_q     <= '0;
            cs_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.REQ) begin
                        wr_q    <= bus.WR;
                        addr_q  <= bus.ADDR;
                        wdata_q <= bus.WDATA;
                        be_q    <= bus.BE;
                        rbuf_q  <= '0;
                        busy_q  <= 1'b1;
                        if (bus.BE == 2'b00) begin
                            state_q <= DONE;
                            ack_q   <= 1'b1;
                            if (!bus.WR) rdata_q <= '0;
                        end else begin
                            state_q <= SETUP;
                            sel_q   <= first_sel;
                            a_q     <= {bus.ADDR, first_sel};
                            cs_n_q  <= 1'b0;
                            drive_q <= bus.WR;
                            dout_q  <= bus.BE[0] ? bus.WDATA[7:0] : bus.WDATA[15:8];
                        end
                    end
                end
                SETUP: begin
                    state_q <= STROBE;
                    cnt_q   <= CW'(WC_EFF - 1);
                    if (wr_q) we_n_q <= 1'b0;
                    else      oe_n_q <= 1'b0;
                end
                STROBE: begin
                    if (cnt_q == '0) begin
                        state_q <= HOLD;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        if (!wr_q) begin
                            if (sel_q) rbuf_q[15:8] <= SRAM_D;
                            else       rbuf_q[7:0]  <= SRAM_D;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    // CS stays low across the byte boundary; only address and data move.
                    if (!sel_q && be_q[1]) begin
                        state_q <= SETUP;
                        sel_q   <= 1'b1;
                        a_q     <= {addr_q, 1'b1};
                        dout_q  <= wdata_q[15:8];
                    end else begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                        cs_n_q  <= 1'b1;
                        drive_q <= 1'b0;
                        if (!wr_q) rdata_q <= rbuf_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    assign SRAM_D    = drive_q ? dout_q : 8'bz;
    assign SRAM_A    = a_q;
    assign SRAM_CS   = cs_n_q;
    assign SRAM_OE   = oe_n_q;
    assign SRAM_WE   = we_n_q;
    assign bus.RDATA = rdata_q;
    assign bus.ACK   = ack_q;
    assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_sram_word_master.sv
// tb/tb_sram_word_master.sv - scoreboard bench for sram_word_master with a byte-wide SRAM model
module tb_sram_word_master;
    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    wire  [7:0]  sram_d;
    logic [18:0] sram_a;
    logic        sram_cs, sram_oe, sram_we;
    logic [7:0]  mem [0:1023];
    int          cyc = 0;
    int          nvec = 0;
    int          nfail = 0;

    sram_word_master_if bus ();

    sram_word_master #(.WAIT_CYCLES(WC)) dut (
        .CLK     (clk),
        .NRESET  (nreset),
        .bus     (bus.slave),
        .SRAM_D  (sram_d),
        .SRAM_A  (sram_a),
        .SRAM_CS (sram_cs),
        .SRAM_OE (sram_oe),
        .SRAM_WE (sram_we)
    );

    always #5 clk = ~clk;

    // Floating bus reads back as 0xFF, so any leftover DUT drive is visible.
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (sram_d[i]);
    end

    assign sram_d = (!sram_cs && !sram_oe) ? mem[sram_a[9:0]] : 8'bz;

    initial forever begin
        @(posedge clk);
        if (!sram_cs && !sram_we) mem[sram_a[9:0]] = sram_d;
        cyc++;
    end

    typedef struct {
        int          cyc;
        logic        cs, oe, we, busy, a_chk;
        logic [18:0] a;
        logic [1:0]  dm;
        logic [7:0]  dv;
    } pin_t;

    typedef struct {
        int          cyc;
        logic        rd;
        logic [15:0] rdata;
    } ack_t;

    pin_t pq[$];
    ack_t aq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push_pin(input int c, input logic cs, input logic oe, input logic we,
                            input logic busy, input logic a_chk, input logic [18:0] a,
                            input logic [1:0] dm, input logic [7:0] dv);
        pin_t p;
        p.cyc = c; p.cs = cs; p.oe = oe; p.we = we; p.busy = busy;
        p.a_chk = a_chk; p.a = a; p.dm = dm; p.dv = dv;
        pq.push_back(p);
    endtask

    task automatic push_timeline(input int t0, input logic wr, input logic [17:0] addr,
                                 input logic [15:0] wdata, input logic [1:0] be);
        int j = 0;
        int done;
        for (int l = 0; l < 2; l++) begin
            if (be[l]) begin
                int          base;
                logic [18:0] ba;
                logic [7:0]  b;
                base = t0 + j * (WC + 2);
                ba   = {addr, 1'(l)};
                b    = (l == 1) ? wdata[15:8] : wdata[7:0];
                push_pin(base + 1, 0, 1, 1, 1, 1, ba, wr ? 2'd2 : 2'd1, b);
                for (int k = 0; k < WC; k++)
                    push_pin(base + 2 + k, 0, wr, !wr, 1, 1, ba, wr ? 2'd2 : 2'd0, b);
                push_pin(base + WC + 2, 0, 1, 1, 1, 1, ba, wr ? 2'd2 : 2'd1, b);
                j++;
            end
        end
        done = t0 + j * (WC + 2) + 1;
        push_pin(done,     1, 1, 1, 1, 0, '0, 2'd1, 8'h00);
        push_pin(done + 1, 1, 1, 1, 0, 0, '0, 2'd1, 8'h00);
    endtask

    task automatic issue(input logic wr, input logic [17:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be, input int ack_rel, input logic [15:0] exp_rd,
                         input bit keep, input bit track, output int t0);
        ack_t a;
        int   n = 0;
        t0 = -1;
        @(negedge clk);
        bus.REQ = 1'b1; bus.WR = wr; bus.ADDR = addr; bus.WDATA = wdata; bus.BE = be;
        while (bus.BUSY && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.BUSY) begin
            nvec++; nfail++;
            $display("FAIL accept_timeout: BUSY still 1 after %0d cycles, required 0", n);
            bus.REQ = 1'b0;
            return;
        end
        t0 = cyc;
        if (track) begin
            push_timeline(t0, wr, addr, wdata, be);
            a.cyc = t0 + ack_rel; a.rd = !wr; a.rdata = exp_rd;
            aq.push_back(a);
        end
        @(posedge clk);
        if (!keep) begin
            @(negedge clk);
            bus.REQ = 1'b0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        while (pq.size() > 0 && pq[0].cyc < cyc) begin
            nvec++; nfail++;
            $display("FAIL pin_missed: entry for cycle %0d not checked, now %0d", pq[0].cyc, cyc);
            void'(pq.pop_front());
        end
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            pin_t p;
            p = pq.pop_front();
            chk("cs",   32'(sram_cs),  32'(p.cs));
            chk("oe",   32'(sram_oe),  32'(p.oe));
            chk("we",   32'(sram_we),  32'(p.we));
            chk("busy", 32'(bus.BUSY), 32'(p.busy));
            if (p.a_chk)     chk("addr",   32'(sram_a), 32'(p.a));
            if (p.dm == 2'd2) chk("wdata",  32'(sram_d), 32'(p.dv));
            if (p.dm == 2'd1) chk("d_idle", 32'(sram_d), 32'hFF);
        end
        if (bus.ACK) begin
            if (aq.size() == 0) begin
                nvec++; nfail++;
                $display("FAIL spurious_ack: ACK=1 at cycle %0d, required 0", cyc);
            end else begin
                ack_t a;
                a = aq.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(a.cyc));
                if (a.rd) chk("rdata", 32'(bus.RDATA), 32'(a.rdata));
            end
        end
    end

    task automatic chk_idle_pins(input string name);
        chk({name, "_cs"},   32'(sram_cs),   32'd1);
        chk({name, "_oe"},   32'(sram_oe),   32'd1);
        chk({name, "_we"},   32'(sram_we),   32'd1);
        chk({name, "_d"},    32'(sram_d),    32'hFF);
        chk({name, "_ack"},  32'(bus.ACK),   32'd0);
        chk({name, "_busy"}, 32'(bus.BUSY),  32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((pq.size() > 0 || aq.size() > 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (pq.size() > 0 || aq.size() > 0) begin
            nvec++; nfail++;
            $display("FAIL drain_timeout: %0d pin and %0d ack entries left, required 0", pq.size(), aq.size());
            pq.delete();
            aq.delete();
        end
    endtask

    initial begin
        int t0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        bus.REQ = 1'b0; bus.WR = 1'b0; bus.ADDR = '0; bus.WDATA = '0; bus.BE = '0;
        repeat (3) @(negedge clk);
        chk_idle_pins("rst");
        chk("rst_addr",  32'(sram_a),    32'd0);
        chk("rst_rdata", 32'(bus.RDATA), 32'd0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        issue(1'b1, 18'h00012, 16'hBEEF, 2'b11, 9, 16'h0000, 1'b0, 1'b1, t0);
        drain();
        chk("mem_024", 32'(mem[10'h024]), 32'hEF);
        chk("mem_025", 32'(mem[10'h025]), 32'hBE);

        issue(1'b0, 18'h00012, 16'h0000, 2'b11, 9, 16'hBEEF, 1'b0, 1'b1, t0);
        drain();

        mem[10'h025] = 8'h5A;
        issue(1'b0, 18'h00012, 16'h0000, 2'b10, 5, 16'h5A00, 1'b0, 1'b1, t0);
        drain();
        issue(1'b0, 18'h00012, 16'h0000, 2'b01, 5, 16'h00EF, 1'b0, 1'b1, t0);
        drain();
        issue(1'b0, 18'h00012, 16'h0000, 2'b00, 1, 16'h0000, 1'b0, 1'b1, t0);
        drain();

        issue(1'b1, 18'h00100, 16'h1234, 2'b11, 9, 16'h0000, 1'b1, 1'b1, t0);
        issue(1'b1, 18'h00101, 16'hAB55, 2'b01, 5, 16'h0000, 1'b0, 1'b1, t0);
        drain();
        chk("mem_200", 32'(mem[10'h200]), 32'h34);
        chk("mem_201", 32'(mem[10'h201]), 32'h12);
        chk("mem_202", 32'(mem[10'h202]), 32'h55);
        chk("mem_203", 32'(mem[10'h203]), 32'h00);

        issue(1'b0, 18'h00100, 16'h0000, 2'b11, 9, 16'h1234, 1'b0, 1'b1, t0);
        drain();

        issue(1'b1, 18'h00012, 16'h1111, 2'b11, 9, 16'h0000, 1'b1, 1'b0, t0);
        @(posedge clk);
        @(posedge clk);
        #2 nreset = 1'b0;
        #1;
        chk_idle_pins("abort");
        chk("abort_rdata", 32'(bus.RDATA), 32'd0);
        chk("abort_addr",  32'(sram_a),    32'd0);
        bus.REQ = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk_idle_pins("post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
